// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: assembles a checksummed byte stream into
// words, writes them to the instruction memory and stalls the CPU until done.
module imem_loader #(
    parameter int ISIZE = 32,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    input  logic             start,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [ISIZE-1:0] wr_data,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int BPW = ISIZE / 8;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    // Number of addressable words; images longer than this overflow.
    localparam logic [16:0] DEPTH = (AW >= 16) ? 17'h10000 : 17'(1 << AW);

    typedef enum logic [2:0] {
        IDLE,
        HDR0,
        HDR1,
        DATA,
        CHK,
        DONE
    } state_e;

    state_e            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [BW-1:0]     byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_cnt_q, word_cnt_d;
    logic [ISIZE-1:0]  word_q, word_d;
    logic [7:0]        xor_q, xor_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [AW-1:0]     wr_addr_q, wr_addr_d;
    logic [ISIZE-1:0]  wr_data_q, wr_data_d;

    logic              accept;
    logic              last_byte;
    logic              last_word;
    logic              in_range;
    logic [ISIZE-1:0]  word_asm;

    assign in_ready  = (state_q == HDR0) || (state_q == HDR1) ||
                       (state_q == DATA) || (state_q == CHK);
    assign accept    = in_valid && in_ready;
    assign last_byte = (byte_cnt_q == BW'(BPW - 1));
    assign last_word = (word_cnt_q == (n_q - 16'd1));
    assign in_range  = ({1'b0, word_cnt_q} < DEPTH);

    // Current word with the incoming byte merged at its little-endian slot.
    always_comb begin
        word_asm = word_q;
        word_asm[{byte_cnt_q, 3'b000} +: 8] = in_data;
    end

    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        state_d    = state_q;
        n_d        = n_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_d     = word_q;
        xor_d      = xor_q;
        err_d      = err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;

        case (state_q)
            IDLE: state_d = HDR0;

            HDR0: begin
                if (accept) begin
                    n_d[7:0] = in_data;
                    state_d  = HDR1;
                end
            end

            HDR1: begin
                if (accept) begin
                    n_d[15:8] = in_data;
                    state_d   = ({in_data, n_q[7:0]} != 16'd0) ? DATA : CHK;
                end
            end

            DATA: begin
                if (accept) begin
                    xor_d  = xor_q ^ in_data;
                    word_d = word_asm;
                    if (last_byte) begin
                        byte_cnt_d = '0;
                        word_cnt_d = word_cnt_q + 16'd1;
                        if (in_range) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = AW'(word_cnt_q);
                            wr_data_d = word_asm;
                        end else begin
                            err_d = 1'b1;
                        end
                        if (last_word) begin
                            state_d = CHK;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BW'(1);
                    end
                end
            end

            CHK: begin
                if (accept) begin
                    if (in_data != xor_q) begin
                        err_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                if (start) begin
                    state_d    = HDR0;
                    n_d        = '0;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    word_d     = '0;
                    xor_d      = '0;
                    err_d      = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            n_q        <= '0;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_q     <= '0;
            xor_q      <= '0;
            err_q      <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_q     <= word_d;
            xor_q      <= xor_d;
            err_q      <= err_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign err      = err_q;
    assign done     = (state_q == DONE);
    assign cpu_hold = (state_q != DONE);

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory of the 4-stage pipelined CPU. It accepts a byte stream over a valid/ready handshake, assembles bytes into instruction words, and issues single-cycle writes to the instruction memory's write port. It holds the pipeline stalled through `cpu_hold` until a complete, checksum-verified image has been written, and it can be re-armed to load a new image.

## Interface
Parameters:
- `ISIZE`, 32: instruction word width in bits. Must be a multiple of 8.
- `AW`, 8: instruction memory address width. Depth is 2^AW words.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `in_valid`  input  1  a stream byte is present on `in_data`.
- `in_data`  input  8  stream byte.
- `in_ready`  output  1  the loader accepts a byte this cycle.
- `start`  input  1  single-cycle pulse that re-arms the loader; honoured only in DONE.
- `wr_en`  output  1  instruction memory write strobe, one cycle per word.
- `wr_addr`  output  AW  word address of the write.
- `wr_data`  output  ISIZE  word being written.
- `cpu_hold`  output  1  holds the PC and pipeline; high whenever the state is not DONE.
- `done`  output  1  the image load is complete.
- `err`  output  1  sticky flag for overflow or checksum mismatch; valid when `done` is high.

## Operation
- Stream format: 2-byte word count N (little-endian), then N×(ISIZE/8) data bytes, then 1 checksum byte.
- Each word is little-endian: the first byte goes to bits [7:0].
- The checksum is the XOR of all data bytes. Header bytes are not included.
- A byte is accepted on a rising edge where `in_valid && in_ready`. Any number of idle cycles between bytes is legal.
- State machine:
  - IDLE → HDR0 unconditionally.
  - HDR0 → HDR1 on accept; latches N[7:0].
  - HDR1 → DATA on accept if N≠0, else → CHK; latches N[15:8].
  - DATA → CHK on accept of the last data byte.
  - CHK → DONE on accept.
  - DONE → HDR0 on `start`.
- `in_ready` = 1 in HDR0, HDR1, DATA and CHK; 0 in IDLE and DONE.
- Byte counter: counts 0..ISIZE/8−1 within a word. The word counter counts 0..N−1.
- Word write: on the edge that accepts the last byte of a word, the loader registers `wr_en`=1, `wr_data` = the assembled word and `wr_addr` = the word index. The write is visible the following cycle.
- Overflow: a word with index ≥ 2^AW is not written (`wr_en` stays 0) and sets `err`. All bytes are still consumed and included in the checksum.
- CHK: `err` is set if the received byte ≠ the accumulated XOR.
- On entry to HDR0 from DONE, the loader clears `err`, the XOR accumulator and all counters.
- `wr_addr` does not wrap past 2^AW−1.

## Timing
- Reset values:
  - state IDLE, `in_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0.
  - `cpu_hold` 1, `done` 0, `err` 0, counters 0.
- `in_ready` first rises 1 cycle after `rst` deasserts.
- Write latency: `wr_en` is high exactly 1 cycle, in the cycle after the word's last byte is accepted.
- `done` rises and `cpu_hold` falls in the cycle after the checksum byte is accepted. The final `wr_en` pulse, if any, has already completed by then.
- Maximum throughput is 1 byte per cycle. A back-to-back word writes on consecutive ISIZE/8-cycle boundaries.
- `start` outside DONE is ignored. On `start` in DONE, `cpu_hold` rises and `done` falls on the next cycle.
- Reset mid-load: the loader returns to IDLE immediately and asynchronously, and the partial image is abandoned. Memory contents already written are not restored.

## Test plan
- Nominal load, ISIZE=32. Send 02 00 44 33 22 11 DD CC BB AA 44.
  - Required: `wr_en` at addr 0 with 0x11223344, then at addr 1 with 0xAABBCCDD.
  - Then `done`=1, `err`=0, `cpu_hold`=0.
- Empty image. Send 00 00 00.
  - Required: no `wr_en`, then `done`=1, `err`=0.
- Bad checksum. Same as nominal but the last byte is 0x45.
  - Required: both words written, `done`=1, `err`=1.
- Overflow, AW=2. Send N=5 with words 0..4 and the correct checksum.
  - Required: writes only to addr 0–3, no fifth `wr_en`, `done`=1, `err`=1.
- Throttled stream. Nominal image with random 0–3-cycle `in_valid` gaps.
  - Required: identical writes and `done` timing relative to the final accept.
  - Also required: `start` pulsed during HDR1 is ignored.
- Reset and reload.
  - Assert `rst` after 5 data bytes. Required: IDLE, `in_ready`=0, `cpu_hold`=1 asynchronously.
  - Then run the nominal load, pulse `start`, and run the nominal load again. Required: `err` cleared and the same writes repeated.
